// File: rtl/operand_fetch_if.sv
// Handshake bundle between decode, regfile, writeback and execute
// for the operand fetch stage.
interface operand_fetch_if #(
  parameter int WORDSIZE = 32,
  parameter int REG_AW   = 5,
  parameter int CTRL_W   = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [REG_AW-1:0]   in_rs1;
  logic [REG_AW-1:0]   in_rs2;
  logic [REG_AW-1:0]   in_rd;
  logic                in_rd_we;
  logic [CTRL_W-1:0]   in_ctrl;
  logic [REG_AW-1:0]   rf_read1;
  logic [REG_AW-1:0]   rf_read2;
  logic [WORDSIZE-1:0] rf_out1;
  logic [WORDSIZE-1:0] rf_out2;
  logic                wb_regwrite;
  logic [REG_AW-1:0]   wb_write1;
  logic [WORDSIZE-1:0] wb_data;
  logic                wb_retire;
  logic [REG_AW-1:0]   wb_retire_rd;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [WORDSIZE-1:0] out_op1;
  logic [WORDSIZE-1:0] out_op2;
  logic [REG_AW-1:0]   out_rd;
  logic                out_rd_we;
  logic [CTRL_W-1:0]   out_ctrl;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd,
    input  in_rd_we, in_ctrl,
    input  rf_out1, rf_out2,
    input  wb_regwrite, wb_write1, wb_data,
    input  wb_retire, wb_retire_rd, flush,
    input  out_ready,
    output in_ready, rf_read1, rf_read2,
    output out_valid, out_op1, out_op2,
    output out_rd, out_rd_we, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd,
    output in_rd_we, in_ctrl,
    output rf_out1, rf_out2,
    output wb_regwrite, wb_write1, wb_data,
    output wb_retire, wb_retire_rd, flush,
    output out_ready,
    input  in_ready, rf_read1, rf_read2,
    input  out_valid, out_op1, out_op2,
    input  out_rd, out_rd_we, out_ctrl
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: regfile read, writeback bypass, busy scoreboard
// with RAW/WAW stalls, one output register toward execute.
module operand_fetch_stage #(
  parameter int WORDSIZE = 32,
  parameter int REG_NUM  = 32,
  parameter int REG_AW   = 5,
  parameter int CTRL_W   = 16
) (
  input logic CLK,
  input logic reset,
  operand_fetch_if.slave bus
);

  logic [REG_NUM-1:0]  busy_q, busy_d;
  logic [REG_NUM-1:0]  ret_mask, eff_busy;
  logic                valid_q, valid_d;
  logic [WORDSIZE-1:0] op1_q, op1_d;
  logic [WORDSIZE-1:0] op2_q, op2_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                rd_we_q, rd_we_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                hazard, ready, accept;
  logic [WORDSIZE-1:0] src1, src2;

  assign bus.rf_read1 = bus.in_rs1;
  assign bus.rf_read2 = bus.in_rs2;

  always_comb begin
    ret_mask = '0;
    if (bus.wb_retire) ret_mask[bus.wb_retire_rd] = 1'b1;
  end

  // x0 is masked out so it can never look busy
  assign eff_busy = busy_q & ~ret_mask
                  & {{(REG_NUM-1){1'b1}}, 1'b0};

  assign hazard = eff_busy[bus.in_rs1]
                | eff_busy[bus.in_rs2]
                | (bus.in_rd_we & eff_busy[bus.in_rd]);

  assign ready  = ~reset & ~bus.flush & ~hazard
                & (~valid_q | bus.out_ready);
  assign accept = bus.in_valid & ready;

  assign bus.in_ready = ready;

  always_comb begin
    src1 = bus.rf_out1;
    unique case (1'b1)
      (bus.in_rs1 == '0): src1 = '0;
      (bus.in_rs1 != '0) && bus.wb_regwrite
        && (bus.wb_write1 == bus.in_rs1):
        src1 = bus.wb_data;
      default: src1 = bus.rf_out1;
    endcase
  end

  always_comb begin
    src2 = bus.rf_out2;
    unique case (1'b1)
      (bus.in_rs2 == '0): src2 = '0;
      (bus.in_rs2 != '0) && bus.wb_regwrite
        && (bus.wb_write1 == bus.in_rs2):
        src2 = bus.wb_data;
      default: src2 = bus.rf_out2;
    endcase
  end

  always_comb begin
    busy_d  = busy_q & ~ret_mask;
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    ctrl_d  = ctrl_q;
    // a flushed writer never retires, so release its register here
    if (bus.flush && valid_q && rd_we_q && rd_q != '0)
      busy_d[rd_q] = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      op1_d   = src1;
      op2_d   = src2;
      rd_d    = bus.in_rd;
      rd_we_d = bus.in_rd_we;
      ctrl_d  = bus.in_ctrl;
      if (bus.in_rd_we && bus.in_rd != '0)
        busy_d[bus.in_rd] = 1'b1;
    end else if (bus.flush || bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_op1   = op1_q;
  assign bus.out_op2   = op2_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_rd_we = rd_we_q;
  assign bus.out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table followed by
// random traffic against a pending-writer set model.
module tb_operand_fetch_stage;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  operand_fetch_if #(.WORDSIZE(32), .REG_AW(5), .CTRL_W(16)) bus();

  operand_fetch_stage #(
    .WORDSIZE(32), .REG_NUM(32), .REG_AW(5), .CTRL_W(16)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          rst;
    bit          valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    bit          we;
    logic [15:0] ctrl;
    bit          ordy;
    bit          flush;
    bit          wbw;
    logic [4:0]  wbi;
    logic [31:0] wbd;
    bit          ret;
    logic [4:0]  rrd;
  } vec_t;

  typedef struct {
    vec_t        v;
    bit          er;
    bit          eov;
    logic [31:0] eop1;
    logic [31:0] eop2;
  } row_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] regs [32];

  bit          m_valid = 0;
  logic [31:0] m_op1 = '0;
  logic [31:0] m_op2 = '0;
  logic [4:0]  m_rd = '0;
  bit          m_we = 0;
  logic [15:0] m_ctrl = '0;
  bit          pend [32];
  int          dsq [$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit eff(vec_t v, logic [4:0] r);
    return r != 0 && pend[r] && !(v.ret && v.rrd == r);
  endfunction

  function automatic logic [31:0] opv(vec_t v, logic [4:0] s);
    if (s == 0) return 32'h0;
    if (v.wbw && v.wbi == s) return v.wbd;
    return regs[s];
  endfunction

  function automatic vec_t mk(bit rst, bit val,
      logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
      bit we, bit ordy, bit fl);
    vec_t v;
    v = '{default: 0};
    v.rst = rst; v.valid = val;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we;
    v.ordy = ordy; v.flush = fl;
    return v;
  endfunction

  task automatic step(vec_t v, bit tbl, bit er, bit eov,
                      logic [31:0] eop1, logic [31:0] eop2);
    bit hz, rdy, acc;
    @(negedge CLK);
    reset            = v.rst;
    bus.in_valid     = v.valid;
    bus.in_rs1       = v.rs1;
    bus.in_rs2       = v.rs2;
    bus.in_rd        = v.rd;
    bus.in_rd_we     = v.we;
    bus.in_ctrl      = v.ctrl;
    bus.rf_out1      = regs[v.rs1];
    bus.rf_out2      = regs[v.rs2];
    bus.wb_regwrite  = v.wbw;
    bus.wb_write1    = v.wbi;
    bus.wb_data      = v.wbd;
    bus.wb_retire    = v.ret;
    bus.wb_retire_rd = v.rrd;
    bus.flush        = v.flush;
    bus.out_ready    = v.ordy;
    #1;
    hz  = eff(v, v.rs1) || eff(v, v.rs2) || (v.we && eff(v, v.rd));
    rdy = !v.rst && !v.flush && !hz && (!m_valid || v.ordy);
    acc = v.valid && rdy;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("rf_read1", 32'(bus.rf_read1), 32'(v.rs1));
    chk("rf_read2", 32'(bus.rf_read2), 32'(v.rs2));
    if (tbl) chk("tbl_in_ready", 32'(bus.in_ready), 32'(er));

    if (v.rst) begin
      foreach (pend[i]) pend[i] = 0;
      dsq.delete();
      m_valid = 0; m_op1 = '0; m_op2 = '0;
      m_rd = '0; m_we = 0; m_ctrl = '0;
    end else begin
      if (m_valid && v.ordy && !v.flush && m_we && m_rd != 0)
        dsq.push_back(int'(m_rd));
      if (v.ret) begin
        pend[v.rrd] = 0;
        foreach (dsq[i])
          if (dsq[i] == int'(v.rrd)) begin
            dsq.delete(i);
            break;
          end
      end
      if (v.flush && m_valid && m_we && m_rd != 0)
        pend[m_rd] = 0;
      if (acc) begin
        if (v.we && v.rd != 0) pend[v.rd] = 1;
        m_valid = 1;
        m_op1 = opv(v, v.rs1);
        m_op2 = opv(v, v.rs2);
        m_rd = v.rd; m_we = v.we; m_ctrl = v.ctrl;
      end else if (v.flush || v.ordy) begin
        m_valid = 0;
      end
    end

    @(posedge CLK);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_op1", bus.out_op1, m_op1);
    chk("out_op2", bus.out_op2, m_op2);
    chk("out_rd", 32'(bus.out_rd), 32'(m_rd));
    chk("out_rd_we", 32'(bus.out_rd_we), 32'(m_we));
    chk("out_ctrl", 32'(bus.out_ctrl), 32'(m_ctrl));
    if (tbl) begin
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(eov));
      chk("tbl_out_op1", bus.out_op1, eop1);
      chk("tbl_out_op2", bus.out_op2, eop2);
    end
  endtask

  row_t tv [20];

  initial begin
    vec_t v;
    foreach (regs[i]) regs[i] = 32'h100 + 32'(i);
    regs[5] = 32'h11;
    foreach (pend[i]) pend[i] = 0;

    tv[0]  = '{mk(1,1,1,0,0,0,1,0), 0,0,32'h0,32'h0};
    tv[1]  = '{mk(1,1,1,0,0,0,1,0), 0,0,32'h0,32'h0};
    tv[2]  = '{mk(0,1,5,0,1,0,1,0), 1,1,32'hAA,32'h0};
    tv[2].v.wbw = 1; tv[2].v.wbi = 5; tv[2].v.wbd = 32'hAA;
    tv[3]  = '{mk(0,1,2,3,7,1,1,0), 1,1,32'h102,32'h103};
    tv[4]  = '{mk(0,1,7,0,0,0,1,0), 0,0,32'h102,32'h103};
    tv[5]  = '{mk(0,1,7,0,0,0,1,0), 0,0,32'h102,32'h103};
    tv[6]  = '{mk(0,1,7,0,0,0,1,0), 1,1,32'h77,32'h0};
    tv[6].v.ret = 1; tv[6].v.rrd = 7;
    tv[6].v.wbw = 1; tv[6].v.wbi = 7; tv[6].v.wbd = 32'h77;
    tv[7]  = '{mk(0,1,1,0,2,0,0,0), 0,1,32'h77,32'h0};
    tv[8]  = '{mk(0,1,1,0,2,0,0,0), 0,1,32'h77,32'h0};
    tv[9]  = '{mk(0,1,1,0,2,0,0,0), 0,1,32'h77,32'h0};
    tv[10] = '{mk(0,1,1,0,2,0,1,0), 1,1,32'h101,32'h0};
    tv[11] = '{mk(0,1,0,0,9,1,1,0), 1,1,32'h0,32'h0};
    tv[12] = '{mk(0,1,9,0,0,0,0,1), 0,0,32'h0,32'h0};
    tv[13] = '{mk(0,1,9,0,0,0,1,0), 1,1,32'h109,32'h0};
    tv[14] = '{mk(0,1,0,0,0,1,1,0), 1,1,32'h0,32'h0};
    tv[15] = '{mk(0,1,0,0,4,0,1,0), 1,1,32'h0,32'h0};
    tv[16] = '{mk(0,1,1,0,3,1,1,0), 1,1,32'h101,32'h0};
    tv[17] = '{mk(0,1,2,0,3,1,1,0), 0,0,32'h101,32'h0};
    tv[18] = '{mk(0,1,2,0,3,1,1,0), 1,1,32'h102,32'h0};
    tv[18].v.ret = 1; tv[18].v.rrd = 3;
    tv[19] = '{mk(0,0,0,0,0,0,1,0), 1,0,32'h102,32'h0};

    for (int i = 0; i < 20; i++) begin
      tv[i].v.ctrl = 16'(i * 16'h0101 + 1);
      step(tv[i].v, 1, tv[i].er, tv[i].eov,
           tv[i].eop1, tv[i].eop2);
    end

    for (int n = 0; n < 2000; n++) begin
      v = '{default: 0};
      regs[$urandom_range(31)] = $urandom;
      v.rst   = ($urandom_range(63) == 0);
      v.valid = ($urandom_range(3) != 0);
      v.rs1   = 5'($urandom_range(7));
      v.rs2   = 5'($urandom_range(7));
      v.rd    = 5'($urandom_range(7));
      v.we    = ($urandom_range(3) != 0);
      v.ctrl  = 16'($urandom);
      v.ordy  = ($urandom_range(3) != 0);
      v.flush = ($urandom_range(15) == 0);
      v.wbw   = ($urandom_range(1) == 1);
      v.wbi   = 5'($urandom_range(7));
      v.wbd   = $urandom;
      if (dsq.size() > 0 && $urandom_range(2) == 0) begin
        v.ret = 1;
        v.rrd = 5'(dsq[$urandom_range(dsq.size() - 1)]);
      end
      step(v, 0, 0, 0, 32'h0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
